apb_arb2: RTL

APB_ARB2 -- requirements
Module: apb_arb2

---
 rtl/apb_arb2_if.sv | 54 +++++
 rtl/apb_arb2.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/apb_arb2_if.sv
// Bus bundle between two requesters, the arbiter and the APB mux.
// The master modport is the arbiter's view; slave is the requester/mux side.
`timescale 1ns/1ps
`ifndef ADDR_APB
`define ADDR_APB 32
`endif
`ifndef DATA_APB
`define DATA_APB 32
`endif

interface apb_arb2_if;
    logic                 m0_req;
    logic                 m0_rw;
    logic [`ADDR_APB-1:0] m0_addr;
    logic [`DATA_APB-1:0] m0_wdata;
    logic                 m0_ack;
    logic [`DATA_APB-1:0] m0_rdata;
    logic                 m0_err;

    logic                 m1_req;
    logic                 m1_rw;
    logic [`ADDR_APB-1:0] m1_addr;
    logic [`DATA_APB-1:0] m1_wdata;
    logic                 m1_ack;
    logic [`DATA_APB-1:0] m1_rdata;
    logic                 m1_err;

    logic                 apb_valid;
    logic                 apb_psel;
    logic                 apb_rw;
    logic                 apb_enab;
    logic [`ADDR_APB-1:0] apb_addr;
    logic [`DATA_APB-1:0] apb_datai;
    logic [`DATA_APB-1:0] apb_datao;
    logic                 apb_ack;

    modport master (
        input  m0_req, m0_rw, m0_addr, m0_wdata,
        input  m1_req, m1_rw, m1_addr, m1_wdata,
        output m0_ack, m0_rdata, m0_err,
        output m1_ack, m1_rdata, m1_err,
        output apb_valid, apb_psel, apb_rw, apb_enab, apb_addr, apb_datai,
        input  apb_datao, apb_ack
    );

    modport slave (
        output m0_req, m0_rw, m0_addr, m0_wdata,
        output m1_req, m1_rw, m1_addr, m1_wdata,
        input  m0_ack, m0_rdata, m0_err,
        input  m1_ack, m1_rdata, m1_err,
        input  apb_valid, apb_psel, apb_rw, apb_enab, apb_addr, apb_datai,
        output apb_datao, apb_ack
    );
endinterface

// File: rtl/apb_arb2.sv
// Two-requester round-robin arbiter driving one APB transfer at a time.
// Optional ACCESS-phase watchdog enabled by defining APB_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
`ifndef ADDR_APB
`define ADDR_APB 32
`endif
`ifndef DATA_APB
`define DATA_APB 32
`endif

module apb_arb2
`ifdef APB_ARB_TIMEOUT_EN
    #(parameter logic [7:0] TIMEOUT_CYC = 8'd255)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    apb_arb2_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e               state_q;
    logic                 last_grant_q;
    logic                 gnt_q;
    logic                 m0_ack_q, m1_ack_q;
    logic                 m0_err_q, m1_err_q;
    logic [`DATA_APB-1:0] m0_rdata_q, m1_rdata_q;
    logic                 apb_valid_q, apb_psel_q, apb_enab_q, apb_rw_q;
    logic [`ADDR_APB-1:0] apb_addr_q;
    logic [`DATA_APB-1:0] apb_datai_q;
`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0]           cnt_q;
`endif

    logic elig0, elig1, any_elig, gnt_d;

    // A requester being acked this cycle still holds req; mask it so the other wins.
    always_comb begin
        elig0    = bus.m0_req & ~m0_ack_q;
        elig1    = bus.m1_req & ~m1_ack_q;
        any_elig = elig0 | elig1;
        gnt_d    = elig1 & (~elig0 | ~last_grant_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            apb_valid_q  <= 1'b0;
            apb_psel_q   <= 1'b0;
            apb_enab_q   <= 1'b0;
            apb_rw_q     <= 1'b0;
            apb_addr_q   <= '0;
            apb_datai_q  <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q        <= 8'd0;
`endif
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_elig) begin
                        state_q      <= SETUP;
                        gnt_q        <= gnt_d;
                        last_grant_q <= gnt_d;
                        apb_rw_q     <= gnt_d ? bus.m1_rw    : bus.m0_rw;
                        apb_addr_q   <= gnt_d ? bus.m1_addr  : bus.m0_addr;
                        apb_datai_q  <= gnt_d ? bus.m1_wdata : bus.m0_wdata;
                        apb_psel_q   <= 1'b1;
                        apb_valid_q  <= 1'b1;
                        apb_enab_q   <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q    <= ACCESS;
                    apb_enab_q <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_q      <= 8'd0;
`endif
                end
                ACCESS: begin
                    if (bus.apb_ack) begin
                        state_q     <= IDLE;
                        apb_psel_q  <= 1'b0;
                        apb_valid_q <= 1'b0;
                        apb_enab_q  <= 1'b0;
                        if (gnt_q) begin
                            m1_ack_q <= 1'b1;
                            if (!apb_rw_q) m1_rdata_q <= bus.apb_datao;
                        end else begin
                            m0_ack_q <= 1'b1;
                            if (!apb_rw_q) m0_rdata_q <= bus.apb_datao;
                        end
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    // Abort: ack with error, read data deliberately left untouched.
                    else if (cnt_q == TIMEOUT_CYC - 8'd1) begin
                        state_q     <= IDLE;
                        apb_psel_q  <= 1'b0;
                        apb_valid_q <= 1'b0;
                        apb_enab_q  <= 1'b0;
                        if (gnt_q) begin
                            m1_ack_q <= 1'b1;
                            m1_err_q <= 1'b1;
                        end else begin
                            m0_ack_q <= 1'b1;
                            m0_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m0_ack    = m0_ack_q;
    assign bus.m1_ack    = m1_ack_q;
    assign bus.m0_err    = m0_err_q;
    assign bus.m1_err    = m1_err_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.apb_valid = apb_valid_q;
    assign bus.apb_psel  = apb_psel_q;
    assign bus.apb_enab  = apb_enab_q;
    assign bus.apb_rw    = apb_rw_q;
    assign bus.apb_addr  = apb_addr_q;
    assign bus.apb_datai = apb_datai_q;

endmodule
